// File: rtl/mem_port_arb_pkg.sv
// Shared sizes and types for the memory port arbiter: channel ids,
// read-tag format and the round-robin pointer step.
package mem_arb_pkg;

  localparam int NCH    = 3;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int BE_W   = DATA_W / 8;
  localparam int ID_W   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef logic [ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } rd_tag_t;

  // Pointer step used after a grant: wrap from the last channel back to 0.
  function automatic ch_id_t next_id(input ch_id_t id);
    if (int'(id) >= NCH - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of per-channel request/response signals and the memory-side port.
// The arbiter uses the slave view; the channel agents and memory model use the master view.
interface mem_port_arb_if;
  import mem_arb_pkg::*;

  logic [NCH-1:0]        ch_wr_vld;
  logic [NCH-1:0]        ch_wr_rdy;
  logic [NCH*ADDR_W-1:0] ch_wr_addr;
  logic [NCH*DATA_W-1:0] ch_wr_data;
  logic [NCH*BE_W-1:0]   ch_wr_be;
  logic [NCH-1:0]        ch_rd_vld;
  logic [NCH-1:0]        ch_rd_rdy;
  logic [NCH*ADDR_W-1:0] ch_rd_addr;
  logic [NCH-1:0]        ch_rsp_vld;
  logic [DATA_W-1:0]     ch_rsp_data;

  logic                  mem_wen;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdin;
  logic [BE_W-1:0]       mem_wb;
  logic                  mem_ren;
  logic [ADDR_W-1:0]     mem_raddr;
  logic                  mem_rvld;
  logic [DATA_W-1:0]     mem_rdout;

  modport slave (
    input  ch_wr_vld, ch_wr_addr, ch_wr_data, ch_wr_be,
    input  ch_rd_vld, ch_rd_addr,
    input  mem_rvld, mem_rdout,
    output ch_wr_rdy, ch_rd_rdy, ch_rsp_vld, ch_rsp_data,
    output mem_wen, mem_waddr, mem_wdin, mem_wb, mem_ren, mem_raddr
  );

  modport master (
    output ch_wr_vld, ch_wr_addr, ch_wr_data, ch_wr_be,
    output ch_rd_vld, ch_rd_addr,
    output mem_rvld, mem_rdout,
    input  ch_wr_rdy, ch_rd_rdy, ch_rsp_vld, ch_rsp_data,
    input  mem_wen, mem_waddr, mem_wdin, mem_wb, mem_ren, mem_raddr
  );

endinterface

// File: rtl/mem_port_arb_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or above ptr,
// searching upward and wrapping modulo N.
module rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
        found    = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one write and one read port of the DDR memory model between NCH channels.
// Independent round-robin per port, registered memory side, tagged 1-cycle read responses.
module mem_port_arb
  import mem_arb_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);

  ch_id_t            wr_ptr;
  ch_id_t            rd_ptr;
  ch_id_t            wr_id;
  ch_id_t            rd_id;
  logic [NCH-1:0]    wr_gnt;
  logic [NCH-1:0]    rd_gnt;
  logic              wr_any;
  logic              rd_any;
  logic              hazard;
  logic              rd_take;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic [BE_W-1:0]   wr_be_sel;
  logic [ADDR_W-1:0] rd_addr_sel;
  rd_tag_t           tag_s0;
  rd_tag_t           tag_s1;

  rr_arb #(.N(NCH), .IW(ID_W)) u_wr_arb (
    .req    (bus.ch_wr_vld),
    .ptr    (wr_ptr),
    .gnt    (wr_gnt),
    .gnt_id (wr_id),
    .any    (wr_any)
  );

  rr_arb #(.N(NCH), .IW(ID_W)) u_rd_arb (
    .req    (bus.ch_rd_vld),
    .ptr    (rd_ptr),
    .gnt    (rd_gnt),
    .gnt_id (rd_id),
    .any    (rd_any)
  );

  always_comb begin
    wr_addr_sel = bus.ch_wr_addr[int'(wr_id)*ADDR_W +: ADDR_W];
    wr_data_sel = bus.ch_wr_data[int'(wr_id)*DATA_W +: DATA_W];
    wr_be_sel   = bus.ch_wr_be[int'(wr_id)*BE_W +: BE_W];
    rd_addr_sel = bus.ch_rd_addr[int'(rd_id)*ADDR_W +: ADDR_W];
  end

  // A read colliding with the concurrent write is held off one cycle so it sees the new data.
  always_comb begin
    hazard  = wr_any && rd_any && (wr_addr_sel == rd_addr_sel);
    rd_take = rd_any && !hazard;
  end

  assign bus.ch_wr_rdy   = wr_gnt;
  assign bus.ch_rd_rdy   = rd_take ? rd_gnt : '0;
  assign bus.ch_rsp_data = bus.mem_rdout;

  always_comb begin
    bus.ch_rsp_vld = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_rsp_vld[i] = bus.mem_rvld && tag_s1.valid && (tag_s1.id == ch_id_t'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      bus.mem_wen   <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdin  <= '0;
      bus.mem_wb    <= '0;
    end else begin
      bus.mem_wen <= wr_any;
      if (wr_any) begin
        wr_ptr        <= next_id(wr_id);
        bus.mem_waddr <= wr_addr_sel;
        bus.mem_wdin  <= wr_data_sel;
        bus.mem_wb    <= wr_be_sel;
      end
    end
  end

  // Tag stage 0 lines up with mem_ren, stage 1 with mem_rvld one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      bus.mem_ren   <= 1'b0;
      bus.mem_raddr <= '0;
      tag_s0        <= '0;
      tag_s1        <= '0;
    end else begin
      bus.mem_ren <= rd_take;
      if (rd_take) begin
        rd_ptr        <= next_id(rd_id);
        bus.mem_raddr <= rd_addr_sel;
      end
      tag_s0 <= '{valid: rd_take, id: rd_id};
      tag_s1 <= tag_s0;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a behavioural byte-enabled memory
// that answers mem_ren one cycle later.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mem_port_arb_if bus();

  mem_port_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];

  always @(posedge clk) begin
    bus.mem_rvld <= (bus.mem_ren === 1'b1);
    if (bus.mem_ren === 1'b1) begin
      bus.mem_rdout <= mem_model.exists(bus.mem_raddr) ? mem_model[bus.mem_raddr] : '0;
    end
    if (bus.mem_wen === 1'b1) begin : wr_blk
      logic [DATA_W-1:0] w;
      w = mem_model.exists(bus.mem_waddr) ? mem_model[bus.mem_waddr] : '0;
      for (int b = 0; b < BE_W; b++) begin
        if (bus.mem_wb[b]) w[b*8 +: 8] = bus.mem_wdin[b*8 +: 8];
      end
      mem_model[bus.mem_waddr] = w;
    end
  end

  task automatic idle();
    bus.ch_wr_vld = '0;
    bus.ch_rd_vld = '0;
  endtask

  task automatic set_wr(input int ch, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    bus.ch_wr_vld[ch] = 1'b1;
    bus.ch_wr_addr[ch*ADDR_W +: ADDR_W] = a;
    bus.ch_wr_data[ch*DATA_W +: DATA_W] = d;
    bus.ch_wr_be[ch*BE_W +: BE_W] = be;
  endtask

  task automatic set_rd(input int ch, input logic [ADDR_W-1:0] a);
    bus.ch_rd_vld[ch] = 1'b1;
    bus.ch_rd_addr[ch*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ch_wr_addr = '0;
    bus.ch_wr_data = '0;
    bus.ch_wr_be   = '0;
    bus.ch_rd_addr = '0;
    repeat (2) @(negedge clk);
    tests++; if (bus.mem_wen !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_wen got %b want 0", bus.mem_wen); end
    tests++; if (bus.mem_ren !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_ren got %b want 0", bus.mem_ren); end
    tests++; if (bus.mem_waddr !== '0 || bus.mem_raddr !== '0) begin fails++; $display("[TB] FAIL reset_addr got w=%h r=%h want 0", bus.mem_waddr, bus.mem_raddr); end
    tests++; if (bus.mem_wdin !== '0 || bus.mem_wb !== '0) begin fails++; $display("[TB] FAIL reset_wdata got wb=%h want 0", bus.mem_wb); end
    tests++; if (bus.ch_rsp_vld !== 3'b000) begin fails++; $display("[TB] FAIL reset_rsp_vld got %b want 000", bus.ch_rsp_vld); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    for (int ch = 0; ch < 3; ch++) set_wr(ch, ADDR_W'(28'h100 + ch), DATA_W'(ch + 1), '1);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = 3'b001 << (k % 3);
      tests++; if (bus.ch_wr_rdy !== exp) begin fails++; $display("[TB] FAIL rr_grant_%0d got %b want %b", k, bus.ch_wr_rdy, exp); end
      tests++; if (bus.ch_rd_rdy !== 3'b000) begin fails++; $display("[TB] FAIL rr_no_rd_%0d got %b want 000", k, bus.ch_rd_rdy); end
      if (k > 0) begin
        tests++; if (bus.mem_waddr !== ADDR_W'(28'h100 + (k - 1) % 3) || bus.mem_wen !== 1'b1) begin fails++; $display("[TB] FAIL rr_waddr_%0d got %h wen %b want %h", k, bus.mem_waddr, bus.mem_wen, 28'h100 + (k - 1) % 3); end
      end
      @(negedge clk);
    end
    idle();
    tests++; if (bus.mem_waddr !== 28'h102) begin fails++; $display("[TB] FAIL rr_last_waddr got %h want 102", bus.mem_waddr); end
  endtask

  task automatic test_single_write_read();
    set_wr(1, 28'h10, {32{8'hA5}}, '1);
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b010) begin fails++; $display("[TB] FAIL single_wr_rdy got %b want 010", bus.ch_wr_rdy); end
    @(negedge clk);
    idle();
    tests++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 28'h10) begin fails++; $display("[TB] FAIL single_mem_wen got wen %b addr %h want 1 010", bus.mem_wen, bus.mem_waddr); end
    tests++; if (bus.mem_wdin !== {32{8'hA5}} || bus.mem_wb !== {BE_W{1'b1}}) begin fails++; $display("[TB] FAIL single_wdata got wb %h want all ones", bus.mem_wb); end
    set_rd(1, 28'h10);
    #1;
    tests++; if (bus.ch_rd_rdy !== 3'b010) begin fails++; $display("[TB] FAIL single_rd_rdy got %b want 010", bus.ch_rd_rdy); end
    @(negedge clk);
    idle();
    tests++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 28'h10 || bus.mem_wen !== 1'b0) begin fails++; $display("[TB] FAIL single_mem_ren got ren %b addr %h wen %b want 1 010 0", bus.mem_ren, bus.mem_raddr, bus.mem_wen); end
    tests++; if (bus.ch_rsp_vld !== 3'b000) begin fails++; $display("[TB] FAIL single_rsp_early got %b want 000", bus.ch_rsp_vld); end
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b010) begin fails++; $display("[TB] FAIL single_rsp_vld got %b want 010", bus.ch_rsp_vld); end
    tests++; if (bus.ch_rsp_data !== {32{8'hA5}}) begin fails++; $display("[TB] FAIL single_rsp_data got %h want a5..", bus.ch_rsp_data); end
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b000) begin fails++; $display("[TB] FAIL single_rsp_pulse got %b want 000", bus.ch_rsp_vld); end
  endtask

  task automatic test_raw_hazard();
    set_wr(0, 28'h20, {16{16'h1111}}, '1);
    set_rd(2, 28'h20);
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b001) begin fails++; $display("[TB] FAIL raw_wr_rdy got %b want 001", bus.ch_wr_rdy); end
    tests++; if (bus.ch_rd_rdy !== 3'b000) begin fails++; $display("[TB] FAIL raw_rd_stall got %b want 000", bus.ch_rd_rdy); end
    @(negedge clk);
    bus.ch_wr_vld = '0;
    #1;
    tests++; if (bus.ch_rd_rdy !== 3'b100) begin fails++; $display("[TB] FAIL raw_rd_retry got %b want 100", bus.ch_rd_rdy); end
    tests++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0) begin fails++; $display("[TB] FAIL raw_ports got wen %b ren %b want 1 0", bus.mem_wen, bus.mem_ren); end
    @(negedge clk);
    idle();
    tests++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 28'h20) begin fails++; $display("[TB] FAIL raw_mem_ren got %b addr %h want 1 020", bus.mem_ren, bus.mem_raddr); end
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b100 || bus.ch_rsp_data !== {16{16'h1111}}) begin fails++; $display("[TB] FAIL raw_rsp got vld %b data %h want 100 1111..", bus.ch_rsp_vld, bus.ch_rsp_data); end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    set_wr(0, 28'h30, {8{32'hDEADBEEF}}, '1);
    set_rd(1, 28'h40);
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b001 || bus.ch_rd_rdy !== 3'b010) begin fails++; $display("[TB] FAIL par_rdy got wr %b rd %b want 001 010", bus.ch_wr_rdy, bus.ch_rd_rdy); end
    @(negedge clk);
    idle();
    tests++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b1) begin fails++; $display("[TB] FAIL par_both got wen %b ren %b want 1 1", bus.mem_wen, bus.mem_ren); end
    tests++; if (bus.mem_waddr !== 28'h30 || bus.mem_raddr !== 28'h40) begin fails++; $display("[TB] FAIL par_addr got w %h r %h want 030 040", bus.mem_waddr, bus.mem_raddr); end
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b010 || bus.ch_rsp_data !== '0) begin fails++; $display("[TB] FAIL par_rsp got vld %b data %h want 010 0", bus.ch_rsp_vld, bus.ch_rsp_data); end
  endtask

  task automatic test_partial_write();
    @(negedge clk);
    set_wr(2, 28'h50, '1, '1);
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b100) begin fails++; $display("[TB] FAIL part_full_rdy got %b want 100", bus.ch_wr_rdy); end
    @(negedge clk);
    set_wr(2, 28'h50, '0, BE_W'(32'h0000_000F));
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b100) begin fails++; $display("[TB] FAIL part_be_rdy got %b want 100", bus.ch_wr_rdy); end
    @(negedge clk);
    idle();
    set_rd(0, 28'h50);
    #1;
    tests++; if (bus.ch_rd_rdy !== 3'b001) begin fails++; $display("[TB] FAIL part_rd_rdy got %b want 001", bus.ch_rd_rdy); end
    tests++; if (bus.mem_wb !== BE_W'(32'h0000_000F)) begin fails++; $display("[TB] FAIL part_mem_wb got %h want f", bus.mem_wb); end
    @(negedge clk);
    idle();
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b001 || bus.ch_rsp_data !== {{28{8'hFF}}, 32'h0}) begin fails++; $display("[TB] FAIL part_rsp got vld %b data %h want 001 ff..ff00000000", bus.ch_rsp_vld, bus.ch_rsp_data); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    set_rd(1, 28'h10);
    set_wr(1, 28'h90, {8{32'h12345678}}, '1);
    #1;
    tests++; if (bus.ch_rd_rdy !== 3'b010 || bus.ch_wr_rdy !== 3'b010) begin fails++; $display("[TB] FAIL mid_accept got rd %b wr %b want 010 010", bus.ch_rd_rdy, bus.ch_wr_rdy); end
    @(negedge clk);
    idle();
    rst = 1'b1;
    tests++; if (bus.mem_ren !== 1'b1) begin fails++; $display("[TB] FAIL mid_mem_ren got %b want 1", bus.mem_ren); end
    @(negedge clk);
    tests++; if (bus.mem_rvld !== 1'b1 || bus.ch_rsp_vld !== 3'b000) begin fails++; $display("[TB] FAIL mid_dropped got rvld %b rsp %b want 1 000", bus.mem_rvld, bus.ch_rsp_vld); end
    tests++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin fails++; $display("[TB] FAIL mid_ports_reset got ren %b wen %b want 0 0", bus.mem_ren, bus.mem_wen); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.ch_rsp_vld !== 3'b000) begin fails++; $display("[TB] FAIL mid_no_rsp got %b want 000", bus.ch_rsp_vld); end
    for (int ch = 0; ch < 3; ch++) begin
      set_wr(ch, ADDR_W'(28'h60 + ch), '0, '1);
      set_rd(ch, ADDR_W'(28'h70 + ch));
    end
    #1;
    tests++; if (bus.ch_wr_rdy !== 3'b001 || bus.ch_rd_rdy !== 3'b001) begin fails++; $display("[TB] FAIL mid_ptr_zero got wr %b rd %b want 001 001", bus.ch_wr_rdy, bus.ch_rd_rdy); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write_read();
    test_raw_hazard();
    test_parallel();
    test_partial_write();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
